// File: rtl/fdivsqrt_sequencer_pkg.sv
// Shared types for the divide/square-root sequencer.
package fdivsqrt_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/fdivsqrt_resid_eval.sv
// Residual evaluation: resolves the carry-save residual and flags its sign and zero.
module fdivsqrt_resid_eval #(
  parameter int W = 64
) (
  input  logic [W-1:0] ws,
  input  logic [W-1:0] wc,
  output logic         neg,
  output logic         zero
);

  logic [W-1:0] w_sum;

  assign w_sum = ws + wc;
  assign neg   = w_sum[W-1];
  assign zero  = (w_sum == '0);

endmodule

// File: rtl/fdivsqrt_sequencer.sv
// Divide/sqrt sequencer: accepts one op, steps the iterator, captures the root and sticky bit.
//   state | meaning
//   IDLE  | ready for a request
//   BUSY  | iterator stepping; captures result on count-out or zero residual
//   DONE  | result held on the response port until taken
import fdivsqrt_sequencer_pkg::*;

module fdivsqrt_sequencer #(
  parameter int DIVb = 60,
  parameter int CNTW = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqSqrt,
  input  logic [CNTW-1:0]   ReqCycles,
  input  logic              ReqSpecial,
  input  logic              Flush,
  output logic              IFDivStartE,
  output logic              FDivBusyE,
  output logic              SqrtE,
  input  logic [DIVb+3:0]   FirstWS,
  input  logic [DIVb+3:0]   FirstWC,
  input  logic [DIVb:0]     FirstU,
  input  logic [DIVb:0]     FirstUM,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DIVb:0]     RspQ,
  output logic              RspSticky,
  output logic              RspSpecial
);

  seq_state_e       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             stepped_q, stepped_d;
  logic             sqrt_q, sqrt_d;
  logic [DIVb:0]    q_q, q_d;
  logic             sticky_q, sticky_d;
  logic             special_q, special_d;
  logic             resid_neg, resid_zero;

  fdivsqrt_resid_eval #(.W(DIVb + 4)) u_resid_eval (
    .ws   (FirstWS),
    .wc   (FirstWC),
    .neg  (resid_neg),
    .zero (resid_zero)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stepped_d   = stepped_q;
    sqrt_d      = sqrt_q;
    q_d         = q_q;
    sticky_d    = sticky_q;
    special_d   = special_q;
    ReqReady    = 1'b0;
    RspValid    = 1'b0;
    IFDivStartE = 1'b0;
    FDivBusyE   = 1'b0;

    case (state_q)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid && !Flush) begin
          if (ReqSpecial) begin
            q_d       = '0;
            sticky_d  = 1'b0;
            special_d = 1'b1;
            state_d   = DONE;
          end else begin
            IFDivStartE = 1'b1;
            FDivBusyE   = 1'b1;
            sqrt_d      = ReqSqrt;
            cnt_d       = ReqCycles;
            stepped_d   = 1'b0;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        if (Flush) begin
          state_d = IDLE;
        // the initial residual is never tested, only post-step ones
        end else if ((cnt_q == '0) || (stepped_q && resid_zero)) begin
          q_d       = resid_neg ? FirstUM : FirstU;
          sticky_d  = !resid_zero;
          special_d = 1'b0;
          state_d   = DONE;
        end else begin
          FDivBusyE = 1'b1;
          cnt_d     = cnt_q - CNTW'(1);
          stepped_d = 1'b1;
        end
      end
      DONE: begin
        RspValid = 1'b1;
        if (Flush || RspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the request's own type is forwarded so the accept cycle sees it directly.
  assign SqrtE      = (state_q == IDLE) ? ReqSqrt : sqrt_q;
  assign RspQ       = q_q;
  assign RspSticky  = sticky_q;
  assign RspSpecial = special_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stepped_q <= 1'b0;
      sqrt_q    <= 1'b0;
      q_q       <= '0;
      sticky_q  <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stepped_q <= stepped_d;
      sqrt_q    <= sqrt_d;
      q_q       <= q_d;
      sticky_q  <= sticky_d;
      special_q <= special_d;
    end
  end

endmodule

// File: tb/tb_fdivsqrt_sequencer.sv
// Self-checking bench for fdivsqrt_sequencer with DIVb=8 and a cycle-level behavioural model.
module tb_fdivsqrt_sequencer;

  localparam int DIVb = 8;
  localparam int CNTW = 7;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ReqValid, ReqReady, ReqSqrt, ReqSpecial, Flush;
  logic [CNTW-1:0]  ReqCycles;
  logic             IFDivStartE, FDivBusyE, SqrtE;
  logic [DIVb+3:0]  FirstWS, FirstWC;
  logic [DIVb:0]    FirstU, FirstUM;
  logic             RspValid, RspReady, RspSticky, RspSpecial;
  logic [DIVb:0]    RspQ;

  int n_cmp = 0;
  int n_err = 0;

  fdivsqrt_sequencer #(.DIVb(DIVb), .CNTW(CNTW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .ReqSqrt     (ReqSqrt),
    .ReqCycles   (ReqCycles),
    .ReqSpecial  (ReqSpecial),
    .Flush       (Flush),
    .IFDivStartE (IFDivStartE),
    .FDivBusyE   (FDivBusyE),
    .SqrtE       (SqrtE),
    .FirstWS     (FirstWS),
    .FirstWC     (FirstWC),
    .FirstU      (FirstU),
    .FirstUM     (FirstUM),
    .RspValid    (RspValid),
    .RspReady    (RspReady),
    .RspQ        (RspQ),
    .RspSticky   (RspSticky),
    .RspSpecial  (RspSpecial)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Residual pair presented in relative cycle c: the zero-sum pair from zero_from onwards.
  function automatic logic [11:0] pick_ws(int c, logic [11:0] ws0, int zero_from, logic [11:0] zws);
    return (zero_from >= 0 && c >= zero_from) ? zws : ws0;
  endfunction
  function automatic logic [11:0] pick_wc(int c, logic [11:0] wc0, int zero_from, logic [11:0] zwc);
    return (zero_from >= 0 && c >= zero_from) ? zwc : wc0;
  endfunction

  task automatic run_op(input string tag, input bit special, input bit sqrt, input int ncyc,
                        input logic [11:0] ws0, input logic [11:0] wc0, input int zero_from,
                        input logic [11:0] zws, input logic [11:0] zwc,
                        input logic [8:0] u, input logic [8:0] um,
                        input int rdy_delay, input int flush_at);
    int t, h, e;
    logic [11:0] wv, wt;
    logic [8:0] exp_q;
    bit exp_st, exp_busy, exp_valid;

    // Model: capture cycle t is the first cycle 1..N+1 that is N+1 or has a zero residual after a step.
    t = 0;
    if (!special) begin
      for (int c = 1; c <= ncyc + 1; c++) begin
        wv = pick_ws(c, ws0, zero_from, zws) + pick_wc(c, wc0, zero_from, zwc);
        if (c == ncyc + 1 || (c >= 2 && wv == 12'd0)) begin
          t = c;
          break;
        end
      end
    end
    wt     = pick_ws(t, ws0, zero_from, zws) + pick_wc(t, wc0, zero_from, zwc);
    exp_q  = special ? 9'd0 : (wt[11] ? um : u);
    exp_st = special ? 1'b0 : (wt != 12'd0);
    h = t + 1 + rdy_delay;
    e = (flush_at >= 1 && flush_at <= h) ? flush_at : h;

    @(negedge clk);
    ReqValid   = 1'b1;
    ReqSpecial = special;
    ReqSqrt    = sqrt;
    ReqCycles  = CNTW'(ncyc);
    Flush      = 1'b0;
    RspReady   = 1'b0;
    FirstWS    = pick_ws(0, ws0, zero_from, zws);
    FirstWC    = pick_wc(0, wc0, zero_from, zwc);
    FirstU     = u;
    FirstUM    = um;
    #1;
    chk({tag, " acc_ready"}, 64'(ReqReady), 64'(1));
    chk({tag, " acc_start"}, 64'(IFDivStartE), 64'(!special));
    chk({tag, " acc_busy"}, 64'(FDivBusyE), 64'(!special));
    chk({tag, " acc_sqrt"}, 64'(SqrtE), 64'(sqrt));

    for (int c = 1; c <= e + 1; c++) begin
      @(negedge clk);
      ReqValid   = 1'b0;
      ReqSpecial = 1'b0;
      ReqSqrt    = ~sqrt;
      ReqCycles  = CNTW'($urandom_range(0, 127));
      FirstWS    = pick_ws(c, ws0, zero_from, zws);
      FirstWC    = pick_wc(c, wc0, zero_from, zwc);
      Flush      = (c == flush_at);
      RspReady   = (c >= h);
      #1;
      if (c == e + 1) begin
        chk({tag, " end_ready"}, 64'(ReqReady), 64'(1));
        chk({tag, " end_valid"}, 64'(RspValid), 64'(0));
        chk({tag, " end_busy"}, 64'(FDivBusyE), 64'(0));
      end else begin
        exp_busy  = !special && (c < t) && (c != flush_at);
        exp_valid = (c >= t + 1);
        chk({tag, " busy"}, 64'(FDivBusyE), 64'(exp_busy));
        chk({tag, " start"}, 64'(IFDivStartE), 64'(0));
        chk({tag, " ready"}, 64'(ReqReady), 64'(0));
        chk({tag, " valid"}, 64'(RspValid), 64'(exp_valid));
        if (!special && c <= t) chk({tag, " sqrt_hold"}, 64'(SqrtE), 64'(sqrt));
        if (exp_valid) begin
          chk({tag, " rsp_q"}, 64'(RspQ), 64'(exp_q));
          chk({tag, " rsp_sticky"}, 64'(RspSticky), 64'(exp_st));
          chk({tag, " rsp_special"}, 64'(RspSpecial), 64'(special));
        end
      end
    end
    Flush    = 1'b0;
    RspReady = 1'b0;
  endtask

  initial begin
    logic [11:0] r_ws, r_wc, r_zws;
    int r_n, r_zf, r_fl;
    bit r_sp;

    reset_n = 1'b0; ReqValid = 1'b0; ReqSqrt = 1'b0; ReqSpecial = 1'b0; Flush = 1'b0;
    ReqCycles = '0; FirstWS = '0; FirstWC = '0; FirstU = '0; FirstUM = '0; RspReady = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(ReqReady), 64'(1));
    chk("rst_valid", 64'(RspValid), 64'(0));
    chk("rst_start", 64'(IFDivStartE), 64'(0));
    chk("rst_busy", 64'(FDivBusyE), 64'(0));
    chk("rst_q", 64'(RspQ), 64'(0));
    chk("rst_sticky", 64'(RspSticky), 64'(0));
    chk("rst_special", 64'(RspSpecial), 64'(0));
    chk("rst_sqrt", 64'(SqrtE), 64'(ReqSqrt));
    @(negedge clk);
    reset_n = 1'b1;

    run_op("pos", 0, 0, 4, 12'h010, 12'h000, -1, 12'h000, 12'h000, 9'h155, 9'h154, 0, -1);
    run_op("neg", 0, 1, 4, 12'h800, 12'h000, -1, 12'h000, 12'h000, 9'h155, 9'h154, 0, -1);
    run_op("early", 0, 0, 10, 12'h010, 12'h000, 3, 12'hFC0, 12'h040, 9'h0A5, 9'h0A4, 0, -1);
    run_op("zero_cycles", 0, 1, 0, 12'h000, 12'h000, -1, 12'h000, 12'h000, 9'h1FF, 9'h1FE, 0, -1);
    run_op("special", 1, 0, 6, 12'h123, 12'h456, -1, 12'h000, 12'h000, 9'h0F0, 9'h0EF, 0, -1);
    run_op("backpressure", 0, 0, 3, 12'h0F0, 12'h00F, -1, 12'h000, 12'h000, 9'h0C3, 9'h0C2, 3, -1);
    run_op("flush_busy", 0, 1, 10, 12'h0F0, 12'h00F, -1, 12'h000, 12'h000, 9'h011, 9'h010, 0, 2);
    run_op("after_flush", 0, 0, 2, 12'hA00, 12'h001, -1, 12'h000, 12'h000, 9'h033, 9'h032, 1, -1);
    run_op("flush_done", 0, 0, 1, 12'h001, 12'h001, -1, 12'h000, 12'h000, 9'h077, 9'h076, 4, 4);

    // Asynchronous reset while BUSY with five steps still to run.
    @(negedge clk);
    ReqValid = 1'b1; ReqSpecial = 1'b0; ReqSqrt = 1'b1; ReqCycles = CNTW'(8);
    FirstWS = 12'h100; FirstWC = 12'h000;
    @(negedge clk);
    ReqValid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rstbusy_pre_busy", 64'(FDivBusyE), 64'(1));
    chk("rstbusy_pre_ready", 64'(ReqReady), 64'(0));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstbusy_ready", 64'(ReqReady), 64'(1));
    chk("rstbusy_busy", 64'(FDivBusyE), 64'(0));
    chk("rstbusy_valid", 64'(RspValid), 64'(0));
    chk("rstbusy_q", 64'(RspQ), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      r_n   = $urandom_range(0, 12);
      r_ws  = 12'($urandom);
      r_wc  = 12'($urandom);
      r_zws = 12'($urandom);
      r_zf  = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, r_n + 2);
      r_sp  = ($urandom_range(0, 7) == 0);
      r_fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, r_n + 3) : -1;
      run_op($sformatf("rand%0d", i), r_sp, 1'($urandom), r_n, r_ws, r_wc, r_zf,
             r_zws, 12'(-r_zws), 9'($urandom), 9'($urandom), $urandom_range(0, 3), r_fl);
    end

    run_op("final", 0, 0, 2, 12'h004, 12'h000, -1, 12'h000, 12'h000, 9'h1A5, 9'h1A4, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
